// File: rtl/udp_receive_pkg.sv
// Shared types and constants for the UDP receive slot scheduler.
package udp_receive_pkg;

  typedef enum logic [1:0] {
    I_IDLE,
    I_WRITE,
    I_DROP
  } ingress_state_type;

  typedef enum logic [1:0] {
    E_IDLE,
    E_DRAIN,
    E_RELEASE
  } egress_state_type;

  // A discarded slot stays unallocatable this long while its FIFO resets.
  localparam int unsigned COOLDOWN_CYCLES = 2;
  localparam int unsigned COOLDOWN_WIDTH  = $clog2(COOLDOWN_CYCLES + 1);

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module round_robin_arbiter #(
  parameter int unsigned SLOT_COUNT       = 4,
  parameter int unsigned SLOT_INDEX_WIDTH = $clog2(SLOT_COUNT)
) (
  input  logic [SLOT_COUNT-1:0]       request_i,
  input  logic [SLOT_INDEX_WIDTH-1:0] pointer_i,
  output logic [SLOT_COUNT-1:0]       grant_o,
  output logic [SLOT_INDEX_WIDTH-1:0] grant_index_o,
  output logic                        grant_valid_o
);

  // Walk the slots starting at the pointer, wrapping once.
  always_comb begin
    int unsigned j;
    j             = 0;
    grant_o       = '0;
    grant_index_o = '0;
    grant_valid_o = 1'b0;
    for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
      j = int'(pointer_i) + i;
      if (j >= SLOT_COUNT) begin
        j = j - SLOT_COUNT;
      end
      if (!grant_valid_o && request_i[j]) begin
        grant_valid_o = 1'b1;
        grant_o[j]    = 1'b1;
        grant_index_o = SLOT_INDEX_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/receive_slot_scheduler.sv
// Allocates ingress packets to free receive slots and round-robins complete
// slots onto a single downstream consumer.
module receive_slot_scheduler
  import udp_receive_pkg::*;
#(
  parameter int unsigned SLOT_COUNT       = 4,
  parameter int unsigned SLOT_INDEX_WIDTH = $clog2(SLOT_COUNT)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [7:0]                   data,
  input  logic                         data_enable,
  input  logic                         packet_start,
  input  logic                         good_packet,
  input  logic                         bad_packet,
  input  logic [SLOT_COUNT-1:0]        slot_ready,
  input  logic [SLOT_COUNT-1:0]        slot_data_ready,
  input  logic [8*SLOT_COUNT-1:0]      slot_push_data,
  input  logic [SLOT_COUNT-1:0]        slot_push_data_valid,
  input  logic [16*SLOT_COUNT-1:0]     slot_ipv4_identification,
  input  logic [16*SLOT_COUNT-1:0]     slot_ipv4_flags,
  output logic [7:0]                   slot_data,
  output logic [SLOT_COUNT-1:0]        slot_data_enable,
  output logic [SLOT_COUNT-1:0]        slot_good_packet,
  output logic [SLOT_COUNT-1:0]        slot_bad_packet,
  output logic [SLOT_COUNT-1:0]        slot_push_data_enable,
  input  logic                         push_data_enable,
  output logic [7:0]                   push_data,
  output logic                         push_data_valid,
  output logic                         frame_active,
  output logic [SLOT_INDEX_WIDTH-1:0]  frame_slot,
  output logic [15:0]                  frame_ipv4_identification,
  output logic [15:0]                  frame_ipv4_flags,
  output logic                         frame_done,
  output logic [15:0]                  dropped_packet_count
);

  typedef logic [SLOT_INDEX_WIDTH-1:0] idx_t;
  typedef logic [COOLDOWN_WIDTH-1:0]   cool_t;

  ingress_state_type     ingress_state_q, ingress_state_d;
  egress_state_type      egress_state_q, egress_state_d;
  idx_t                  ingress_slot_q, ingress_slot_d;
  idx_t                  frame_slot_q, frame_slot_d;
  idx_t                  rr_ptr_q, rr_ptr_d;
  logic                  frame_active_q, frame_active_d;
  logic [15:0]           ident_q, ident_d, flags_q, flags_d;
  logic [15:0]           dropped_count_q, dropped_count_d;
  logic [SLOT_COUNT-1:0] busy_q, busy_d, busy_clr;
  cool_t                 cooldown_q [SLOT_COUNT];
  cool_t                 cooldown_d [SLOT_COUNT];

  logic [SLOT_COUNT-1:0] free_slots;
  logic                  free_any;
  idx_t                  free_idx;
  logic [SLOT_COUNT-1:0] arb_grant;
  idx_t                  arb_idx;
  logic                  arb_valid;
  logic [15:0]           arb_ident, arb_flags;

  assign slot_data                 = data;
  assign frame_active              = frame_active_q;
  assign frame_slot                = frame_slot_q;
  assign frame_ipv4_identification = ident_q;
  assign frame_ipv4_flags          = flags_q;
  assign dropped_packet_count      = dropped_count_q;

  // Lowest-index slot that is idle, not holding a packet and not cooling down.
  always_comb begin
    free_slots = '0;
    free_any   = 1'b0;
    free_idx   = '0;
    for (int k = SLOT_COUNT - 1; k >= 0; k--) begin
      free_slots[k] = slot_ready[k] & ~busy_q[k] & (cooldown_q[k] == '0);
      if (free_slots[k]) begin
        free_any = 1'b1;
        free_idx = idx_t'(k);
      end
    end
  end

  round_robin_arbiter #(
    .SLOT_COUNT       (SLOT_COUNT),
    .SLOT_INDEX_WIDTH (SLOT_INDEX_WIDTH)
  ) u_arbiter (
    .request_i     (busy_q & slot_data_ready),
    .pointer_i     (rr_ptr_q),
    .grant_o       (arb_grant),
    .grant_index_o (arb_idx),
    .grant_valid_o (arb_valid)
  );

  // Header fields of the slot about to be granted.
  always_comb begin
    arb_ident = '0;
    arb_flags = '0;
    for (int k = 0; k < SLOT_COUNT; k++) begin
      if (arb_grant[k]) begin
        arb_ident = slot_ipv4_identification[16*k +: 16];
        arb_flags = slot_ipv4_flags[16*k +: 16];
      end
    end
  end

  // State registers for both FSMs and the slot bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ingress_state_q <= I_IDLE;
      egress_state_q  <= E_IDLE;
      ingress_slot_q  <= '0;
      frame_slot_q    <= '0;
      rr_ptr_q        <= '0;
      frame_active_q  <= 1'b0;
      ident_q         <= '0;
      flags_q         <= '0;
      dropped_count_q <= '0;
      busy_q          <= '0;
      for (int k = 0; k < SLOT_COUNT; k++) cooldown_q[k] <= '0;
    end else begin
      ingress_state_q <= ingress_state_d;
      egress_state_q  <= egress_state_d;
      ingress_slot_q  <= ingress_slot_d;
      frame_slot_q    <= frame_slot_d;
      rr_ptr_q        <= rr_ptr_d;
      frame_active_q  <= frame_active_d;
      ident_q         <= ident_d;
      flags_q         <= flags_d;
      dropped_count_q <= dropped_count_d;
      busy_q          <= busy_d;
      for (int k = 0; k < SLOT_COUNT; k++) cooldown_q[k] <= cooldown_d[k];
    end
  end

  // Ingress next state: allocate on packet start, return to idle on a verdict.
  always_comb begin
    ingress_state_d = ingress_state_q;
    ingress_slot_d  = ingress_slot_q;
    dropped_count_d = dropped_count_q;
    case (ingress_state_q)
      I_IDLE: begin
        if (packet_start && data_enable) begin
          if (free_any) begin
            ingress_slot_d  = free_idx;
            ingress_state_d = I_WRITE;
          end else begin
            ingress_state_d = I_DROP;
            if (dropped_count_q != 16'hFFFF) dropped_count_d = dropped_count_q + 16'd1;
          end
        end
      end
      I_WRITE, I_DROP: begin
        if (good_packet || bad_packet) ingress_state_d = I_IDLE;
      end
      default: ingress_state_d = I_IDLE;
    endcase
  end

  // Ingress outputs: steer strobes and verdicts to the allocated slot.
  always_comb begin
    slot_data_enable = '0;
    slot_good_packet = '0;
    slot_bad_packet  = '0;
    case (ingress_state_q)
      I_IDLE: begin
        // The first byte lands in the slot being selected this cycle.
        if (packet_start && data_enable && free_any) slot_data_enable[free_idx] = 1'b1;
      end
      I_WRITE: begin
        slot_data_enable[ingress_slot_q] = data_enable;
        if (bad_packet) begin
          slot_bad_packet[ingress_slot_q] = 1'b1;
        end else if (good_packet) begin
          slot_good_packet[ingress_slot_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Slot bookkeeping: good verdict marks busy, release clears, bad starts cooldown.
  always_comb begin
    busy_d = (busy_q | slot_good_packet) & ~busy_clr;
    for (int k = 0; k < SLOT_COUNT; k++) begin
      if (slot_bad_packet[k]) begin
        cooldown_d[k] = cool_t'(COOLDOWN_CYCLES);
      end else if (cooldown_q[k] != '0) begin
        cooldown_d[k] = cooldown_q[k] - 1'b1;
      end else begin
        cooldown_d[k] = '0;
      end
    end
  end

  // Egress next state: grant, drain until the slot empties, then release.
  always_comb begin
    egress_state_d = egress_state_q;
    frame_slot_d   = frame_slot_q;
    frame_active_d = frame_active_q;
    ident_d        = ident_q;
    flags_d        = flags_q;
    rr_ptr_d       = rr_ptr_q;
    case (egress_state_q)
      E_IDLE: begin
        if (arb_valid) begin
          frame_slot_d   = arb_idx;
          ident_d        = arb_ident;
          flags_d        = arb_flags;
          frame_active_d = 1'b1;
          egress_state_d = E_DRAIN;
        end
      end
      E_DRAIN: begin
        if (!slot_data_ready[frame_slot_q]) egress_state_d = E_RELEASE;
      end
      E_RELEASE: begin
        frame_active_d = 1'b0;
        rr_ptr_d       = (frame_slot_q == idx_t'(SLOT_COUNT - 1)) ? '0 : frame_slot_q + 1'b1;
        egress_state_d = E_IDLE;
      end
      default: egress_state_d = E_IDLE;
    endcase
  end

  // Egress outputs: consumer read strobe and byte mux from the granted slot.
  always_comb begin
    busy_clr              = '0;
    frame_done            = 1'b0;
    slot_push_data_enable = '0;
    push_data             = '0;
    push_data_valid       = 1'b0;
    if (frame_active_q) begin
      push_data       = slot_push_data[{frame_slot_q, 3'b000} +: 8];
      push_data_valid = slot_push_data_valid[frame_slot_q];
    end
    case (egress_state_q)
      E_DRAIN:   slot_push_data_enable[frame_slot_q] = push_data_enable;
      E_RELEASE: begin
        busy_clr[frame_slot_q] = 1'b1;
        frame_done             = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_receive_slot_scheduler.sv
// Scoreboard bench: stimulus queues expected slot events, a monitor pops them.
module tb_receive_slot_scheduler;

  localparam int EvWr = 0, EvBad = 1, EvGood = 2, EvGrant = 3, EvPull = 4, EvDone = 5;

  typedef struct {
    int          kind;
    int          slot;
    logic [31:0] val;
  } ev_t;

  logic        clock, reset_n;
  logic [7:0]  data;
  logic        data_enable, packet_start, good_packet, bad_packet;
  logic [3:0]  slot_ready, slot_data_ready, slot_push_data_valid;
  logic [31:0] slot_push_data;
  logic [63:0] slot_ipv4_identification, slot_ipv4_flags;
  logic [7:0]  slot_data;
  logic [3:0]  slot_data_enable, slot_good_packet, slot_bad_packet, slot_push_data_enable;
  logic        push_data_enable;
  logic [7:0]  push_data;
  logic        push_data_valid, frame_active, frame_done;
  logic [1:0]  frame_slot;
  logic [15:0] frame_ipv4_identification, frame_ipv4_flags, dropped_packet_count;

  ev_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pulled [4];
  int          limit [4];
  bit          drain_en [4];
  logic [15:0] id_tbl [4];
  logic [15:0] fl_tbl [4];
  logic        prev_active;

  receive_slot_scheduler #(.SLOT_COUNT(4)) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .data                      (data),
    .data_enable               (data_enable),
    .packet_start              (packet_start),
    .good_packet               (good_packet),
    .bad_packet                (bad_packet),
    .slot_ready                (slot_ready),
    .slot_data_ready           (slot_data_ready),
    .slot_push_data            (slot_push_data),
    .slot_push_data_valid      (slot_push_data_valid),
    .slot_ipv4_identification  (slot_ipv4_identification),
    .slot_ipv4_flags           (slot_ipv4_flags),
    .slot_data                 (slot_data),
    .slot_data_enable          (slot_data_enable),
    .slot_good_packet          (slot_good_packet),
    .slot_bad_packet           (slot_bad_packet),
    .slot_push_data_enable     (slot_push_data_enable),
    .push_data_enable          (push_data_enable),
    .push_data                 (push_data),
    .push_data_valid           (push_data_valid),
    .frame_active              (frame_active),
    .frame_slot                (frame_slot),
    .frame_ipv4_identification (frame_ipv4_identification),
    .frame_ipv4_flags          (frame_ipv4_flags),
    .frame_done                (frame_done),
    .dropped_packet_count      (dropped_packet_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Slot FIFO model: slot k serves bytes k*64+n while drain is enabled and n < limit.
  always_comb begin
    slot_data_ready      = '0;
    slot_push_data_valid = '0;
    slot_push_data       = '0;
    for (int k = 0; k < 4; k++) begin
      slot_data_ready[k]      = drain_en[k] && (pulled[k] < limit[k]);
      slot_push_data_valid[k] = slot_data_ready[k];
      slot_push_data[8*k +: 8] = 8'(k * 64 + pulled[k]);
    end
  end

  function automatic int oh2idx(input logic [3:0] v);
    int n   = 0;
    int idx = -1;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        n++;
        idx = i;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic observe(input int kind, input int slot, input logic [31:0] val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event: got unexpected kind=%0d slot=%0d val=%h, need none", kind, slot, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.slot != slot || e.val !== val) begin
        miscompares++;
        $display("FAIL event: got kind=%0d slot=%0d val=%h, need kind=%0d slot=%0d val=%h",
                 kind, slot, val, e.kind, e.slot, e.val);
      end
    end
  endtask

  // Monitor: turn each cycle's visible outputs into events in a fixed order.
  initial begin
    prev_active = 1'b0;
    for (int k = 0; k < 4; k++) pulled[k] = 0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (slot_data_enable != 4'b0) observe(EvWr, oh2idx(slot_data_enable), {24'h0, slot_data});
        if (slot_bad_packet != 4'b0) observe(EvBad, oh2idx(slot_bad_packet), 32'h0);
        if (slot_good_packet != 4'b0) observe(EvGood, oh2idx(slot_good_packet), 32'h0);
        if (frame_active && !prev_active)
          observe(EvGrant, int'(frame_slot), {frame_ipv4_identification, frame_ipv4_flags});
        if (push_data_valid && push_data_enable)
          observe(EvPull, oh2idx(slot_push_data_enable), {24'h0, push_data});
        if (frame_done) observe(EvDone, int'(frame_slot), 32'h0);
      end
      prev_active = frame_active;
      for (int k = 0; k < 4; k++) begin
        if (slot_push_data_enable[k] && slot_push_data_valid[k]) pulled[k]++;
      end
    end
  end

  task automatic push(input int kind, input int slot, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.slot = slot;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] need);
    vectors++;
    if (act !== need) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h", name, act, need);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout with %0d events outstanding, need 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  // exp_slot < 0 means the packet is expected to be dropped (no slot strobes).
  task automatic send_packet(input int len, input int exp_slot, input bit bad,
                             input logic [7:0] seed);
    for (int i = 0; i < len; i++) begin
      packet_start = (i == 0);
      data_enable  = 1'b1;
      data         = seed + 8'(i);
      if (exp_slot >= 0) push(EvWr, exp_slot, {24'h0, data});
      tick();
    end
    packet_start = 1'b0;
    data_enable  = 1'b0;
    if (bad) bad_packet = 1'b1;
    else good_packet = 1'b1;
    if (exp_slot >= 0) push(bad ? EvBad : EvGood, exp_slot, 32'h0);
    tick();
    good_packet = 1'b0;
    bad_packet  = 1'b0;
  endtask

  // Queue a whole granted frame of len bytes from slot k and enable its drain.
  task automatic expect_frame(input int k, input int len);
    int base = pulled[k];
    push(EvGrant, k, {id_tbl[k], fl_tbl[k]});
    for (int j = 0; j < len; j++) push(EvPull, k, {24'h0, 8'(k * 64 + base + j)});
    push(EvDone, k, 32'h0);
    limit[k]    = base + len;
    drain_en[k] = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " frame_active"}, {31'h0, frame_active}, 32'h0);
    check({tag, " frame_slot"}, {30'h0, frame_slot}, 32'h0);
    check({tag, " frame_done"}, {31'h0, frame_done}, 32'h0);
    check({tag, " dropped_count"}, {16'h0, dropped_packet_count}, 32'h0);
    check({tag, " slot_data_enable"}, {28'h0, slot_data_enable}, 32'h0);
    check({tag, " slot_good_packet"}, {28'h0, slot_good_packet}, 32'h0);
    check({tag, " slot_bad_packet"}, {28'h0, slot_bad_packet}, 32'h0);
    check({tag, " slot_push_data_enable"}, {28'h0, slot_push_data_enable}, 32'h0);
    check({tag, " push_data"}, {24'h0, push_data}, 32'h0);
    check({tag, " push_data_valid"}, {31'h0, push_data_valid}, 32'h0);
  endtask

  initial begin
    id_tbl = '{16'hA000, 16'h1234, 16'h5555, 16'hBEEF};
    fl_tbl = '{16'h0000, 16'h4000, 16'h2000, 16'h6000};
    for (int k = 0; k < 4; k++) begin
      limit[k]    = 0;
      drain_en[k] = 1'b0;
      slot_ipv4_identification[16*k +: 16] = id_tbl[k];
      slot_ipv4_flags[16*k +: 16]          = fl_tbl[k];
    end
    reset_n = 1'b0;
    data = 8'h00;
    data_enable = 1'b0;
    packet_start = 1'b0;
    good_packet = 1'b0;
    bad_packet = 1'b0;
    push_data_enable = 1'b0;
    slot_ready = 4'b1111;
    repeat (2) tick();
    @(negedge clock);
    check_idle_outputs("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // 10-byte good packet lands in slot 0; next lands in slot 2 while slot 1 is not idle.
    send_packet(10, 0, 1'b0, 8'h10);
    slot_ready = 4'b1101;
    send_packet(4, 2, 1'b0, 8'hC0);
    slot_ready = 4'b1111;
    wait_drain("ingress alloc");

    // Drain slots 0 and 2 in round-robin order from pointer 0.
    push_data_enable = 1'b1;
    expect_frame(0, 3);
    expect_frame(2, 2);
    wait_drain("egress rr 0,2");

    // Bad packet puts slot 0 into cooldown: next packet goes to slot 1, later one to slot 0.
    send_packet(4, 0, 1'b1, 8'h20);
    tick();
    send_packet(2, 1, 1'b0, 8'h30);
    send_packet(3, 0, 1'b0, 8'h40);
    wait_drain("cooldown");

    // Fill slots 2 and 3, then a packet with no free slot is dropped.
    send_packet(2, 2, 1'b0, 8'h50);
    send_packet(2, 3, 1'b0, 8'h58);
    send_packet(3, -1, 1'b0, 8'h60);
    wait_drain("drop");
    check("drop count first", {16'h0, dropped_packet_count}, 32'h1);
    // Preload near saturation; counting 65534 real drops would take far too long.
    force dut.dropped_count_q = 16'hFFFE;
    tick();
    release dut.dropped_count_q;
    send_packet(2, -1, 1'b1, 8'h68);
    check("drop count reach max", {16'h0, dropped_packet_count}, 32'hFFFF);
    send_packet(2, -1, 1'b0, 8'h6C);
    check("drop count saturate", {16'h0, dropped_packet_count}, 32'hFFFF);

    // All four ready; pointer sits at 3, so order is 3,0,1,2 (slot 1 carries 0x1234/0x4000).
    expect_frame(3, 2);
    expect_frame(0, 2);
    expect_frame(1, 3);
    expect_frame(2, 2);
    wait_drain("egress rr 3,0,1,2");

    // Reset in the middle of a drain (held by consumer) and an ingress write.
    send_packet(2, 0, 1'b0, 8'h70);
    push_data_enable = 1'b0;
    push(EvGrant, 0, {id_tbl[0], fl_tbl[0]});
    limit[0]    = pulled[0] + 5;
    drain_en[0] = 1'b1;
    wait_drain("grant before reset");
    packet_start = 1'b1;
    data_enable  = 1'b1;
    data         = 8'h80;
    push(EvWr, 1, 32'h80);
    tick();
    packet_start = 1'b0;
    data         = 8'h81;
    push(EvWr, 1, 32'h81);
    tick();
    data_enable = 1'b0;
    reset_n     = 1'b0;
    tick();
    reset_n          = 1'b1;
    push_data_enable = 1'b1;
    data_enable      = 1'b1;
    data             = 8'h90;
    @(negedge clock);
    check_idle_outputs("mid-reset");
    repeat (4) tick();
    check("busy cleared by reset", {31'h0, frame_active}, 32'h0);
    drain_en[0] = 1'b0;
    data_enable = 1'b0;
    send_packet(2, 0, 1'b0, 8'hA0);
    wait_drain("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/receive_slot_scheduler.md
Name: receive_slot_scheduler

Overview:
- Owns a bank of SLOT_COUNT UDP receive slots.
- Ingress side: picks a free slot when a packet starts, steers bytes and good/bad verdicts to it, and drops the packet when no slot is free.
- Egress side: round-robin arbitration over slots holding complete packets; grants one slot at a time to a single downstream consumer and muxes its byte stream.
- Sits between the UDP/IPv4 parser and the virtual-port transmit path.

Parameters:
SLOT_COUNT, 4, number of receive slots (2..8)
SLOT_INDEX_WIDTH, $clog2(SLOT_COUNT), width of slot index

Ports:
clock  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
data  in  8  ingress byte
data_enable  in  1  ingress byte valid
packet_start  in  1  first byte of packet; coincident with data_enable
good_packet  in  1  current packet complete and valid
bad_packet  in  1  current packet invalid; discard
slot_ready  in  SLOT_COUNT  per-slot idle flag
slot_data_ready  in  SLOT_COUNT  per-slot draining flag
slot_push_data  in  8*SLOT_COUNT  per-slot FWFT byte; slot k at [8k+7:8k]
slot_push_data_valid  in  SLOT_COUNT  per-slot byte valid
slot_ipv4_identification  in  16*SLOT_COUNT  per-slot latched identification
slot_ipv4_flags  in  16*SLOT_COUNT  per-slot latched flags
slot_data  out  8  byte fanned out to all slots (equals data)
slot_data_enable  out  SLOT_COUNT  one-hot write strobe
slot_good_packet  out  SLOT_COUNT  one-hot good verdict
slot_bad_packet  out  SLOT_COUNT  one-hot bad verdict
slot_push_data_enable  out  SLOT_COUNT  one-hot read strobe
push_data_enable  in  1  consumer pull
push_data  out  8  muxed granted-slot byte
push_data_valid  out  1  muxed granted-slot valid
frame_active  out  1  a slot is granted
frame_slot  out  SLOT_INDEX_WIDTH  granted slot index
frame_ipv4_identification  out  16  granted slot identification
frame_ipv4_flags  out  16  granted slot flags
frame_done  out  1  one-cycle pulse at release
dropped_packet_count  out  16  packets dropped for lack of a slot; saturating

Behaviour:
- Reset (reset_n low at posedge): ingress state I_IDLE, egress state E_IDLE, busy mask 0, cooldown counters 0, RR pointer 0, frame_active 0, frame_slot 0, frame_done 0, dropped_packet_count 0.
- All one-hot strobes are 0 in reset. push_data is 0 and push_data_valid is 0 when nothing is granted.
- Free slot k: slot_ready[k]=1, busy[k]=0 and cooldown[k]=0.

Ingress FSM:
- I_IDLE, on packet_start with data_enable:
  - Select the lowest-index free slot and register it as ingress_slot.
  - That first byte is steered to the selected slot combinationally in the same cycle.
  - Go to I_WRITE.
  - If no slot is free, go to I_DROP and increment dropped_packet_count (holds at 0xFFFF).
- I_WRITE:
  - slot_data_enable[ingress_slot] = data_enable, combinational, zero latency.
  - good_packet: pulse slot_good_packet[ingress_slot], set busy[ingress_slot], go to I_IDLE.
  - bad_packet: pulse slot_bad_packet[ingress_slot], load cooldown[ingress_slot]=2, go to I_IDLE.
  - Cooldown covers the slot's registered FIFO reset.
  - good_packet and bad_packet together: bad wins.
- I_DROP: all strobes 0; good_packet or bad_packet returns to I_IDLE.
- packet_start while in I_WRITE or I_DROP is a protocol error and is ignored.
- packet_start in the same cycle as a verdict is ignored; upstream guarantees at least one cycle of gap.
- Cooldown counters decrement to 0, one per cycle.

Egress FSM:
- E_IDLE:
  - Candidates: slots with busy[k]=1 and slot_data_ready[k]=1.
  - Pick the first candidate at or after the RR pointer, modulo SLOT_COUNT.
  - Register frame_slot and the slot's identification/flags; set frame_active.
  - Go to E_DRAIN. Grant latency is 1 cycle from candidate visibility.
- E_DRAIN:
  - slot_push_data_enable[frame_slot] = push_data_enable.
  - push_data and push_data_valid are muxed from frame_slot, combinational.
  - When slot_data_ready[frame_slot]=0, go to E_RELEASE.
- E_RELEASE:
  - Clear busy[frame_slot], clear frame_active, pulse frame_done.
  - RR pointer = frame_slot+1, wrapping at SLOT_COUNT.
  - Return to E_IDLE. The next grant comes no earlier than the cycle after.
- Ingress and egress run independently. A slot cannot be allocated while busy, so ingress and egress never target the same slot.
- A busy set and a busy clear can never hit the same slot index in one cycle.

Decomposition:
- Package udp_receive_pkg: ingress_state_type (I_IDLE, I_WRITE, I_DROP), egress_state_type (E_IDLE, E_DRAIN, E_RELEASE), COOLDOWN_CYCLES=2.
- One sub-module, round_robin_arbiter: request vector + pointer in, one-hot grant + index out, combinational.

Test Plan:
1. All slots ready; packet of 10 bytes then good_packet -> only slot_data_enable[0] pulses 10 times; slot_good_packet=4'b0001; busy[0]=1.
2. Slots 0 and 2 draining after two good packets; consumer holds push_data_enable=1 -> slot 0 granted first, frame_done pulses, then slot 2 granted; RR pointer becomes 3.
3. Packet ending bad_packet on slot 0; a new packet_start 1 cycle later -> allocated to slot 1 (slot 0 in cooldown). A packet 3 cycles later -> slot 0.
4. All 4 slots busy, new packet_start -> no slot strobes; dropped_packet_count goes 0 to 1. Repeat at 0xFFFF -> stays 0xFFFF.
5. Grant slot 1 with identification 0x1234, flags 0x4000 -> frame_ipv4_identification=0x1234, frame_ipv4_flags=0x4000, frame_slot=1; push_data tracks slot 1 bytes.
6. reset_n low for one cycle mid-E_DRAIN and mid-I_WRITE -> next cycle all outputs at reset values; busy=0; dropped_packet_count=0.
